// File: rtl/ps2_keymatrix_if.sv
// ps2_keymatrix_if - host-side bundle of the PS/2 key matrix front end.
// Carries the clock enable, raw PS/2 pins, the row/column matrix bus, the
// map-table write port and the event/hotkey outputs. The event word is
// named evt because "event" is a reserved word.
interface ps2_keymatrix_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CB = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MW = 1 + RB + CB;

  logic            ce;
  logic [1:0]      ps2;
  logic [ROWS-1:0] a;
  logic [COLS-1:0] q;
  logic            mapWe;
  logic [8:0]      mapAddr;
  logic [MW-1:0]   mapData;
  logic            strobe;
  logic [9:0]      evt;
  logic            error;
  logic            nmi;
  logic            boot;
  logic            hostReset;

  modport master (
    output ce, ps2, a, mapWe, mapAddr, mapData,
    input  q, strobe, evt, error, nmi, boot, hostReset
  );

  modport slave (
    input  ce, ps2, a, mapWe, mapAddr, mapData,
    output q, strobe, evt, error, nmi, boot, hostReset
  );
endinterface

// File: rtl/ps2_keymatrix.sv
// ps2_keymatrix - PS/2 keyboard to ROWS x COLS key matrix converter.
// Filters the PS/2 clock, receives 11-bit frames, strips E0/F0/E1 prefixes,
// maps {ext, code} through a run-time loadable table and holds the matrix.
// Optional build macro ERR_CLEAR_EN: any receive error also clears the
// matrix and hotkeys and returns the prefix FSM to IDLE.
//
// state  | meaning
// S_IDLE | waiting for a prefix or key code
// S_EXT  | E0 seen, next code is extended
// S_REL  | F0 seen, next code is a release (ext flag kept)
// S_SKIP | E1 seen, discarding the following 7 bytes
module ps2_keymatrix #(
  parameter int         ROWS    = 8,
  parameter int         COLS    = 8,
  parameter int         TIMEOUT = 4096,
  parameter logic [7:0] NMI     = 8'h03,
  parameter logic [7:0] BOOT    = 8'h78,
  parameter logic [7:0] RESET   = 8'h07
) (
  input logic             clock,
  input logic             reset,
  ps2_keymatrix_if.slave  bus
);
  localparam int RB = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CB = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MW = 1 + RB + CB;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef ERR_CLEAR_EN
  localparam bit ERR_CLEAR = 1'b1;
`else
  localparam bit ERR_CLEAR = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_REL, S_SKIP} state_t;

  logic [7:0]  filt_sr_q, filt_sr_d;
  logic        filt_clk_q, filt_clk_d;
  logic        fall_q, fall_d;
  logic        data_q, data_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic        par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        rx_stb_q, rx_stb_d;
  logic        rx_err_q, rx_err_d;
  logic [ROWS-1:0][COLS-1:0] key_q, key_d;
  logic        nmi_q, nmi_d, boot_q, boot_d, rst_key_q, rst_key_d;

  state_t      state_q;
  logic        ext_q;
  logic [2:0]  skip_q;
  logic        strobe_q;
  logic [9:0]  evt_q;
  logic [MW-1:0] map_rd_q;
  logic [MW-1:0] map_mem [512];

  logic [RB-1:0] map_row;
  logic [CB-1:0] map_col;
  logic [COLS-1:0] q_c;

  assign map_row = map_rd_q[CB +: RB];
  assign map_col = map_rd_q[CB-1:0];

  // Glitch filter on the PS/2 clock and registering of the data line.
  always_comb begin
    filt_sr_d  = filt_sr_q;
    filt_clk_d = filt_clk_q;
    fall_d     = fall_q;
    data_d     = data_q;
    if (bus.ce) begin
      filt_sr_d = {filt_sr_q[6:0], bus.ps2[0]};
      data_d    = bus.ps2[1];
      if (&filt_sr_d)       filt_clk_d = 1'b1;
      else if (~|filt_sr_d) filt_clk_d = 1'b0;
      fall_d = filt_clk_q & ~filt_clk_d;
    end
  end

  // Frame receiver with inter-edge timeout; the parity bit is checked
  // together with the stop bit.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    rx_stb_d  = rx_stb_q;
    rx_err_d  = rx_err_q;
    if (bus.ce) begin
      rx_stb_d = 1'b0;
      rx_err_d = 1'b0;
      if (fall_q) begin
        to_cnt_d = TW'(TIMEOUT);
        if (bit_cnt_q == 4'd0) begin
          if (!data_q) bit_cnt_d = 4'd1;
        end else if (bit_cnt_q <= 4'd8) begin
          rx_sr_d   = {data_q, rx_sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (bit_cnt_q == 4'd9) begin
          par_d     = data_q;
          bit_cnt_d = 4'd10;
        end else begin
          bit_cnt_d = 4'd0;
          if (data_q && (^{rx_sr_q, par_q})) rx_stb_d = 1'b1;
          else                               rx_err_d = 1'b1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (to_cnt_q <= TW'(1)) begin
          bit_cnt_d = 4'd0;
          rx_err_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q - TW'(1);
        end
      end else begin
        to_cnt_d = TW'(TIMEOUT);
      end
    end
  end

  // Matrix and hotkey update, one ce after the table read.
  always_comb begin
    key_d     = key_q;
    nmi_d     = nmi_q;
    boot_d    = boot_q;
    rst_key_d = rst_key_q;
    if (bus.ce) begin
      if (ERR_CLEAR && rx_err_q) begin
        key_d     = '0;
        nmi_d     = 1'b1;
        boot_d    = 1'b1;
        rst_key_d = 1'b1;
      end else if (strobe_q) begin
        if (map_rd_q[MW-1] && (int'(map_row) < ROWS) && (int'(map_col) < COLS))
          key_d[map_row][map_col] = ~evt_q[9];
        if (!evt_q[8]) begin
          if (evt_q[7:0] == NMI)   nmi_d     = evt_q[9];
          if (evt_q[7:0] == BOOT)  boot_d    = evt_q[9];
          if (evt_q[7:0] == RESET) rst_key_d = evt_q[9];
        end
      end
    end
  end

  // Register stage for filter, receiver, matrix and hotkeys.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_sr_q  <= 8'hFF;
      filt_clk_q <= 1'b1;
      fall_q     <= 1'b0;
      data_q     <= 1'b1;
      bit_cnt_q  <= 4'd0;
      rx_sr_q    <= 8'h00;
      par_q      <= 1'b0;
      to_cnt_q   <= TW'(TIMEOUT);
      rx_stb_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      key_q      <= '0;
      nmi_q      <= 1'b1;
      boot_q     <= 1'b1;
      rst_key_q  <= 1'b1;
    end else begin
      filt_sr_q  <= filt_sr_d;
      filt_clk_q <= filt_clk_d;
      fall_q     <= fall_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      rx_stb_q   <= rx_stb_d;
      rx_err_q   <= rx_err_d;
      key_q      <= key_d;
      nmi_q      <= nmi_d;
      boot_q     <= boot_d;
      rst_key_q  <= rst_key_d;
    end
  end

  // Prefix FSM; issues the table read and the event strobe for key codes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ext_q    <= 1'b0;
      skip_q   <= 3'd0;
      strobe_q <= 1'b0;
      evt_q    <= 10'd0;
      map_rd_q <= '0;
    end else if (bus.ce) begin
      strobe_q <= 1'b0;
      if (ERR_CLEAR && rx_err_q) begin
        state_q <= S_IDLE;
        ext_q   <= 1'b0;
        skip_q  <= 3'd0;
      end else if (rx_stb_q) begin
        if (state_q == S_SKIP) begin
          skip_q <= skip_q - 3'd1;
          if (skip_q == 3'd1) state_q <= S_IDLE;
        end else if (rx_sr_q == 8'hE1) begin
          state_q <= S_SKIP;
          skip_q  <= 3'd7;
          ext_q   <= 1'b0;
        end else if (rx_sr_q == 8'hE0) begin
          ext_q <= 1'b1;
          if (state_q == S_IDLE) state_q <= S_EXT;
        end else if (rx_sr_q == 8'hF0) begin
          state_q <= S_REL;
        end else begin
          map_rd_q <= map_mem[{ext_q, rx_sr_q}];
          evt_q    <= {state_q == S_REL, ext_q, rx_sr_q};
          strobe_q <= 1'b1;
          state_q  <= S_IDLE;
          ext_q    <= 1'b0;
        end
      end
    end
  end

  // Map table write port; not gated by ce and never cleared by reset.
  always_ff @(posedge clock) begin
    if (bus.mapWe) map_mem[bus.mapAddr] <= bus.mapData;
  end

  // Column sense: OR of all selected rows.
  always_comb begin
    q_c = '0;
    for (int r = 0; r < ROWS; r++)
      if (bus.a[r]) q_c = q_c | key_q[r];
  end

  assign bus.q         = q_c;
  assign bus.strobe    = strobe_q;
  assign bus.evt       = evt_q;
  assign bus.error     = rx_err_q;
  assign bus.nmi       = nmi_q;
  assign bus.boot      = boot_q;
  assign bus.hostReset = rst_key_q;
endmodule

// File: tb/tb_ps2_keymatrix.sv
// tb_ps2_keymatrix - directed bench for ps2_keymatrix (default build).
module tb_ps2_keymatrix;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n_strobe = 0;
  int   n_err    = 0;
  int   s0, e0;

  ps2_keymatrix_if #(.ROWS(8), .COLS(8)) bus ();

  ps2_keymatrix #(.ROWS(8), .COLS(8), .TIMEOUT(TMO)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.strobe) n_strobe++;
      if (bus.error)  n_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2[1] = b;
    repeat (15) @(negedge clk);
    bus.ps2[0] = 1'b0;
    repeat (20) @(negedge clk);
    bus.ps2[0] = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = ~^b ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic send_partial(input int n);
    ps2_bit(1'b0);
    for (int i = 1; i < n; i++) ps2_bit(1'b1);
    repeat (TMO + 60) @(negedge clk);
  endtask

  task automatic map_wr(input logic [8:0] addr, input logic [6:0] d);
    @(negedge clk);
    bus.mapWe = 1'b1; bus.mapAddr = addr; bus.mapData = d;
    @(negedge clk);
    bus.mapWe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e1_seq [8];
    e1_seq[0] = 8'hE1; e1_seq[1] = 8'h14; e1_seq[2] = 8'h77; e1_seq[3] = 8'hE1;
    e1_seq[4] = 8'hF0; e1_seq[5] = 8'h14; e1_seq[6] = 8'hF0; e1_seq[7] = 8'h77;

    bus.ce = 1'b1; bus.ps2 = 2'b11; bus.a = 8'h00;
    bus.mapWe = 1'b0; bus.mapAddr = 9'd0; bus.mapData = 7'd0;
    repeat (4) @(negedge clk);
    // Start from a fully invalid table, then load the two test entries.
    for (int i = 0; i < 512; i++) map_wr(9'(i), 7'h00);
    map_wr(9'h01C, 7'h41);
    map_wr(9'h175, 7'h73);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    bus.a = 8'hFF; #1;
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_evt", 32'(bus.evt), 32'h000);
    chk("rst_hot", 32'({bus.nmi, bus.boot, bus.hostReset, bus.strobe, bus.error}), 32'b11100);

    // Make and break of a plain key.
    bus.a = 8'h01;
    s0 = n_strobe;
    send_frame(8'h1C, 1'b0);
    chk("make_q", 32'(bus.q), 32'h02);
    chk("make_stb", 32'(n_strobe - s0), 32'd1);
    chk("make_evt", 32'(bus.evt), 32'h01C);
    s0 = n_strobe;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    chk("brk_q", 32'(bus.q), 32'h00);
    chk("brk_evt", 32'(bus.evt), 32'h21C);
    chk("brk_stb", 32'(n_strobe - s0), 32'd1);

    // Extended key, then the same code unextended (unmapped).
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    bus.a = 8'h40; #1;
    chk("ext_q", 32'(bus.q), 32'h08);
    chk("ext_evt", 32'(bus.evt), 32'h175);
    s0 = n_strobe;
    send_frame(8'h75, 1'b0);
    bus.a = 8'hFF; #1;
    chk("unmap_q", 32'(bus.q), 32'h08);
    chk("unmap_stb", 32'(n_strobe - s0), 32'd1);
    chk("unmap_evt", 32'(bus.evt), 32'h075);

    // Parity error then good frame.
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h1C, 1'b1);
    chk("par_err", 32'(n_err - e0), 32'd1);
    chk("par_stb", 32'(n_strobe - s0), 32'd0);
    chk("par_q", 32'(bus.q), 32'h08);
    send_frame(8'h1C, 1'b0);
    chk("post_par_q", 32'(bus.q), 32'h0A);
    chk("post_par_evt", 32'(bus.evt), 32'h01C);

    // Partial frame timeout, then a clean frame.
    e0 = n_err; s0 = n_strobe;
    send_partial(4);
    chk("tmo_err", 32'(n_err - e0), 32'd1);
    send_frame(8'h32, 1'b0);
    chk("tmo_stb", 32'(n_strobe - s0), 32'd1);
    chk("tmo_evt", 32'(bus.evt), 32'h032);

    // E1 sequence swallows 7 bytes.
    s0 = n_strobe;
    for (int i = 0; i < 8; i++) send_frame(e1_seq[i], 1'b0);
    chk("e1_stb", 32'(n_strobe - s0), 32'd0);
    chk("e1_q", 32'(bus.q), 32'h0A);
    send_frame(8'h1C, 1'b0);
    chk("e1_next_stb", 32'(n_strobe - s0), 32'd1);
    chk("e1_next_evt", 32'(bus.evt), 32'h01C);

    // F0 survives a timeout: next code is a release.
    send_frame(8'hF0, 1'b0);
    send_partial(3);
    send_frame(8'h1C, 1'b0);
    chk("f0_tmo_evt", 32'(bus.evt), 32'h21C);
    chk("f0_tmo_q", 32'(bus.q), 32'h08);

    // Hotkeys.
    send_frame(8'h03, 1'b0);
    chk("nmi_press", 32'(bus.nmi), 32'd0);
    send_frame(8'h78, 1'b0);
    chk("boot_press", 32'(bus.boot), 32'd0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h03, 1'b0);
    chk("nmi_rel", 32'(bus.nmi), 32'd1);
    chk("nmi_rel_evt", 32'(bus.evt), 32'h203);

    // Reset with a key and hostReset held; table must survive.
    send_frame(8'h1C, 1'b0);
    send_frame(8'h07, 1'b0);
    chk("hr_press", 32'(bus.hostReset), 32'd0);
    bus.a = 8'h01; #1;
    chk("pre_rst_q", 32'(bus.q), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_q", 32'(bus.q), 32'h00);
    chk("rst2_hr", 32'(bus.hostReset), 32'd1);
    chk("rst2_boot", 32'(bus.boot), 32'd1);
    repeat (10) @(negedge clk);
    send_frame(8'h1C, 1'b0);
    chk("map_kept_q", 32'(bus.q), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
